// File: rtl/dma_pkg.sv
// Shared DMA stream constants and state type for the buffer packer/unpacker pair.
package dma_pkg;
   localparam int unsigned DMA_BEAT_W     = 64;
   localparam int unsigned BEATS_PER_WORD = 2;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } unpack_state_e;
endpackage

// File: rtl/dma_word_fifo2.sv
// Two-entry word FIFO holding BRAM words until both of their DMA beats have been sent.
module dma_word_fifo2 #(
   parameter int unsigned W = 112
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] head,
   output logic [1:0]   count
);
   logic [W-1:0] mem0;
   logic [W-1:0] mem1;
   logic         wr_ptr;
   logic         rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign do_pop  = pop && (count != 2'd0);
   assign do_push = push && (count != 2'd2);
   assign head    = rd_ptr ? mem1 : mem0;

   // Pointer and occupancy state
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         count <= count + 2'(do_push) - 2'(do_pop);
      end
   end

   // Storage is qualified by count, so it needs no reset
   always_ff @(posedge clk) begin
      if (do_push) begin
         if (wr_ptr) mem1 <= wdata;
         else        mem0 <= wdata;
      end
   end
endmodule

// File: rtl/dma_unpack_112.sv
// Reads buffer words from a 1-cycle BRAM port and streams each out as two 64-bit DMA beats.
module dma_unpack_112
   import dma_pkg::*;
#(
   parameter int unsigned IN_W   = 112,
   parameter int unsigned ADDR_W = 7
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [ADDR_W:0]       num_words,
   output logic                  busy,
   output logic                  done,
   output logic                  buf_re,
   output logic [ADDR_W-1:0]     buf_raddr,
   input  logic [IN_W-1:0]       buf_rdata,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DMA_BEAT_W-1:0] m_data,
   output logic                  m_last
);
   localparam int unsigned CNT_W    = ADDR_W + 1;
   localparam int unsigned LAST_SEL = BEATS_PER_WORD - 1;

   unpack_state_e   state;
   logic            rd_pend;
   logic            beat_sel;
   logic [CNT_W-1:0] rd_left;
   logic [CNT_W-1:0] send_left;
   logic [IN_W-1:0] head;
   logic [1:0]      fifo_count;
   logic [1:0]      count_next;
   logic            xfer;
   logic            pop;
   logic            issue;
   logic            accept;

   assign busy    = (state == S_RUN);
   assign accept  = start && (state == S_IDLE);
   assign m_valid = (fifo_count != 2'd0);
   assign xfer    = m_valid && m_ready;
   assign pop     = xfer && (beat_sel == 1'(LAST_SEL));
   assign m_last  = m_valid && (beat_sel == 1'(LAST_SEL)) && (send_left == CNT_W'(1));

   dma_word_fifo2 #(.W(IN_W)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .push  (rd_pend),
      .pop   (pop),
      .wdata (buf_rdata),
      .head  (head),
      .count (fifo_count)
   );

   // Occupancy after this edge; the read in flight this cycle lands one edge later
   always_comb begin
      count_next = fifo_count;
      if (rd_pend) count_next = count_next + 2'd1;
      if (pop)     count_next = count_next - 2'd1;
   end

   assign issue = (state == S_RUN) && (rd_left != '0) &&
                  ((3'(count_next) + 3'(buf_re)) < 3'd2);

   always_comb begin
      m_data = '0;
      if (m_valid) begin
         if (beat_sel) m_data = DMA_BEAT_W'(head[IN_W-1:DMA_BEAT_W]);
         else          m_data = head[DMA_BEAT_W-1:0];
      end
   end

   // Command FSM, read issue and beat sequencing
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         done      <= 1'b0;
         buf_re    <= 1'b0;
         buf_raddr <= '0;
         rd_pend   <= 1'b0;
         beat_sel  <= 1'b0;
         rd_left   <= '0;
         send_left <= '0;
      end else begin
         done    <= 1'b0;
         buf_re  <= 1'b0;
         rd_pend <= buf_re;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (num_words == '0) begin
                     done <= 1'b1;
                  end else begin
                     state     <= S_RUN;
                     buf_re    <= 1'b1;
                     buf_raddr <= base_addr;
                     rd_left   <= num_words - CNT_W'(1);
                     send_left <= num_words;
                     beat_sel  <= 1'b0;
                  end
               end
            end
            S_RUN: begin
               if (issue) begin
                  buf_re    <= 1'b1;
                  buf_raddr <= buf_raddr + ADDR_W'(1);
                  rd_left   <= rd_left - CNT_W'(1);
               end
               if (xfer) begin
                  beat_sel <= ~beat_sel;
                  if (beat_sel == 1'(LAST_SEL)) begin
                     send_left <= send_left - CNT_W'(1);
                     if (send_left == CNT_W'(1)) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dma_unpack_112.sv
// Scoreboard bench for dma_unpack_112: directed commands, expected beats/reads queued at issue.
module tb_dma_unpack_112;
   localparam int unsigned IN_W   = 112;
   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DEPTH  = 128;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   num_words;
   logic              busy;
   logic              done;
   logic              buf_re;
   logic [ADDR_W-1:0] buf_raddr;
   logic [IN_W-1:0]   buf_rdata;
   logic              m_valid;
   logic              m_ready;
   logic [63:0]       m_data;
   logic              m_last;

   logic [IN_W-1:0] mem [DEPTH];
   logic [63:0]     exp_data [$];
   logic            exp_last [$];
   logic [6:0]      exp_addr [$];

   int   n_cmp = 0;
   int   n_err = 0;
   int   beats = 0;
   int   reads_cnt = 0;
   int   pops_cnt = 0;
   logic tb_sel = 1'b0;
   logic prev_stall = 1'b0;
   logic [63:0] prev_data = '0;
   logic prev_last = 1'b0;
   logic rnd_mode = 1'b0;

   always #5 clk = ~clk;

   dma_unpack_112 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .num_words (num_words),
      .busy      (busy),
      .done      (done),
      .buf_re    (buf_re),
      .buf_raddr (buf_raddr),
      .buf_rdata (buf_rdata),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last)
   );

   // 1-cycle latency BRAM model
   always @(posedge clk) if (buf_re) buf_rdata <= mem[buf_raddr];

   always @(posedge clk) begin
      if (rnd_mode) begin
         #1;
         m_ready = ($urandom_range(0, 99) < 40);
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic unexpected(input string name, input logic [63:0] got);
      n_cmp++;
      n_err++;
      $display("FAIL %s: got %0h expected nothing at %0t", name, got, $time);
   endtask

   // Monitor: pops expectations whenever a read or a beat transfer is presented
   always @(negedge clk) begin
      if (!rst_n) begin
         reads_cnt  = 0;
         pops_cnt   = 0;
         tb_sel     = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", 64'(m_valid), 64'd1);
            chk("hold_data", m_data, prev_data);
            chk("hold_last", 64'(m_last), 64'(prev_last));
         end
         if (!busy) chk("re_idle", 64'(buf_re), 64'd0);
         if (busy) chk("outstanding_le2", 64'((reads_cnt + int'(buf_re) - pops_cnt) <= 2), 64'd1);
         if (buf_re) begin
            if (exp_addr.size() == 0) unexpected("read", 64'(buf_raddr));
            else chk("raddr", 64'(buf_raddr), 64'(exp_addr.pop_front()));
            reads_cnt++;
         end
         if (m_valid && m_ready) begin
            if (exp_data.size() == 0) unexpected("beat", m_data);
            else begin
               chk("beat_data", m_data, exp_data.pop_front());
               chk("beat_last", 64'(m_last), 64'(exp_last.pop_front()));
            end
            if (tb_sel) pops_cnt++;
            tb_sel = ~tb_sel;
            beats++;
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
      end
   end

   task automatic push_word(input int addr, input bit last);
      logic [IN_W-1:0] w;
      w = mem[addr];
      exp_addr.push_back(7'(addr));
      exp_data.push_back(w[63:0]);
      exp_last.push_back(1'b0);
      exp_data.push_back(64'(w[111:64]));
      exp_last.push_back(last);
   endtask

   task automatic push_cmd(input int base, input int num);
      for (int i = 0; i < num; i++) push_word((base + i) % DEPTH, i == num - 1);
   endtask

   task automatic pulse_start(input int base, input int num);
      @(posedge clk); #1;
      start = 1'b1;
      base_addr = 7'(base);
      num_words = 8'(num);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int limit);
      int c;
      c = 0;
      while (c < limit && done !== 1'b1) begin
         @(negedge clk);
         c++;
      end
      chk({name, "_done"}, 64'(done), 64'd1);
      chk({name, "_busy_clear"}, 64'(busy), 64'd0);
      @(negedge clk);
      chk({name, "_sb_empty"}, 64'(exp_data.size()), 64'd0);
   endtask

   initial begin
      int b0;
      int c;
      for (int i = 0; i < DEPTH; i++)
         for (int k = 0; k < 14; k++) mem[i][8*k +: 8] = 8'(i + k);
      rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; m_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_buf_re", 64'(buf_re), 64'd0);
      chk("rst_raddr", 64'(buf_raddr), 64'd0);
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_last", 64'(m_last), 64'd0);
      chk("rst_m_data", m_data, 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // 1: base 0, three words, sustained ready; word 0 beats hand-computed
      m_ready = 1'b1;
      exp_addr.push_back(7'd0);
      exp_data.push_back(64'h0706050403020100); exp_last.push_back(1'b0);
      exp_data.push_back(64'h00000d0c0b0a0908); exp_last.push_back(1'b0);
      push_word(1, 1'b0);
      push_word(2, 1'b1);
      @(posedge clk); #1;
      start = 1'b1; base_addr = 7'd0; num_words = 8'd3;
      @(negedge clk);
      chk("t1_busy_c0", 64'(busy), 64'd0);
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("t1_busy_c1", 64'(busy), 64'd1);
      chk("t1_re_c1", 64'(buf_re), 64'd1);
      @(negedge clk);
      chk("t1_valid_c2", 64'(m_valid), 64'd0);
      for (int cy = 3; cy <= 8; cy++) begin
         @(negedge clk);
         chk("t1_valid_run", 64'(m_valid), 64'd1);
         chk("t1_done_run", 64'(done), 64'd0);
      end
      chk("t1_last_c8", 64'(m_last), 64'd1);
      @(negedge clk);
      chk("t1_done_c9", 64'(done), 64'd1);
      chk("t1_busy_c9", 64'(busy), 64'd0);
      chk("t1_valid_c9", 64'(m_valid), 64'd0);
      chk("t1_sb_empty", 64'(exp_data.size()), 64'd0);

      // 2: zero-length command
      @(posedge clk); #1;
      start = 1'b1; base_addr = 7'd5; num_words = 8'd0;
      @(negedge clk);
      chk("t2_done_c0", 64'(done), 64'd0);
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("t2_done_c1", 64'(done), 64'd1);
      chk("t2_busy_c1", 64'(busy), 64'd0);
      @(negedge clk);
      chk("t2_done_c2", 64'(done), 64'd0);
      chk("t2_valid_c2", 64'(m_valid), 64'd0);

      // 3: address wrap 126,127,0,1
      push_cmd(126, 4);
      pulse_start(126, 4);
      wait_done("t3", 200);

      // 4: random backpressure
      b0 = beats;
      push_cmd(40, 5);
      rnd_mode = 1'b1;
      pulse_start(40, 5);
      wait_done("t4", 1000);
      rnd_mode = 1'b0;
      #1 m_ready = 1'b1;
      chk("t4_beats", 64'(beats - b0), 64'd10);

      // 5: reset after three beats, then a fresh single-word command
      m_ready = 1'b1;
      b0 = beats;
      push_cmd(20, 4);
      pulse_start(20, 4);
      c = 0;
      while (beats < b0 + 3 && c < 100) begin
         @(posedge clk);
         c++;
      end
      chk("t5_three_beats", 64'(beats - b0), 64'd3);
      #1 rst_n = 1'b0; m_ready = 1'b0;
      repeat (2) @(posedge clk);
      exp_data.delete(); exp_last.delete(); exp_addr.delete();
      @(negedge clk);
      chk("t5_rst_busy", 64'(busy), 64'd0);
      chk("t5_rst_valid", 64'(m_valid), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1; m_ready = 1'b1;
      @(negedge clk);
      chk("t5_no_stale_valid", 64'(m_valid), 64'd0);
      chk("t5_no_done", 64'(done), 64'd0);
      b0 = beats;
      push_cmd(10, 1);
      pulse_start(10, 1);
      wait_done("t5", 100);
      chk("t5_beats", 64'(beats - b0), 64'd2);

      // 6: full-depth command with an ignored start while busy
      b0 = beats;
      push_cmd(0, 128);
      pulse_start(0, 128);
      repeat (5) @(posedge clk);
      #1 start = 1'b1; base_addr = 7'd50; num_words = 8'd3;
      @(negedge clk);
      chk("t6_busy", 64'(busy), 64'd1);
      @(posedge clk); #1 start = 1'b0;
      wait_done("t6", 2000);
      chk("t6_beats", 64'(beats - b0), 64'd256);
      repeat (5) @(negedge clk);
      chk("t6_idle_valid", 64'(m_valid), 64'd0);
      chk("t6_idle_busy", 64'(busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
